alu_mul_seq: RTL and testbench

- Multi-cycle sequencer that computes a 32-bit unsigned shift-add product (low 32 bits, RV32M MUL semantics) using the core's shared ALU as its only adder.
- Sits beside the single-cycle datapath and drives the ALU's op/operand inputs while busy. The datapath mux gives it ownership of the ALU when `busy` is high.
- Uses valid/ready handshakes on both the start and result sides.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul_seq.sv | 103 ++++++++++
 tb/tb_alu_mul_seq.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, default datapath width and the
// multiply sequencer state type.
package alu_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_seq_state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier (low 32 bits) that borrows the core's shared ALU as its adder.
// Optional macro ALU_MUL_SEQ_EARLY_EXIT_EN ends RUN once no multiplier bits remain.
module alu_mul_seq
  import alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] product,
  output logic            busy,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  mul_seq_state_t  state_q, state_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    product     = '0;
    alu_op      = ALU_ADD;
    alu_a       = '0;
    alu_b       = '0;

    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          mcand_d  = op_a;
          mplier_d = op_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // One partial product per cycle, added through the shared ALU.
        busy     = 1'b1;
        alu_a    = acc_q;
        alu_b    = mplier_q[0] ? mcand_q : '0;
        acc_d    = alu_result;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
        if (mplier_d == '0) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        res_valid = 1'b1;
        product   = acc_q;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: directed table, corner sequences and
// random operands against a plain-arithmetic multiply model.
module tb_alu_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] op_a, op_b;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] product;
  logic        busy;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_result;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Stand-in for the core's shared ALU.
  always_comb begin
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      default: alu_result = 32'h0;
    endcase
  end

  alu_mul_seq dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready),
    .product(product), .busy(busy),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expP;
    int          stall;
  } vec_t;

  function automatic logic [31:0] modelProduct(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] full;
    full = {32'h0, a} * {32'h0, b};
    return full[31:0];
  endfunction

  function automatic int modelLatency(input logic [31:0] b);
`ifdef ALU_MUL_SEQ_EARLY_EXIT_EN
    if (b == 32'h0) return 1;
    for (int i = 31; i >= 0; i--) begin
      if (b[i]) return i + 1;
    end
    return 1;
`else
    return (b == b) ? 32 : 32;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Runs one multiply at the current negedge (block must be IDLE); stall holds
  // res_ready low for that many DONE cycles; pulseAt>0 pulses start_valid in RUN.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expP, input int stall, input int pulseAt);
    int cyc;
    int busyCnt;
    int expLat;
    bit opBad;
    expLat = modelLatency(b);
    checkOutput("start_ready_idle", {31'h0, start_ready}, 32'h1);
    start_valid = 1'b1;
    op_a = a;
    op_b = b;
    res_ready = (stall == 0);
    @(negedge clk);
    start_valid = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    cyc = 1;
    busyCnt = 0;
    opBad = 1'b0;
    while (!res_valid && cyc < 100) begin
      if (busy) busyCnt++;
      if (alu_op !== 4'b0010) opBad = 1'b1;
      if (cyc == pulseAt) begin
        start_valid = 1'b1;
        op_a = 32'h1;
        op_b = 32'h1;
      end else begin
        start_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start_valid = 1'b0;
    checkOutput("res_valid_seen", {31'h0, res_valid}, 32'h1);
    checkOutput("latency", cyc, expLat + 1);
    checkOutput("busy_cycles", busyCnt, expLat);
    checkOutput("alu_op_add", {31'h0, opBad}, 32'h0);
    checkOutput("product", product, expP);
    checkOutput("busy_done", {31'h0, busy}, 32'h0);
    checkOutput("start_ready_done", {31'h0, start_ready}, 32'h0);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      checkOutput("held_valid", {31'h0, res_valid}, 32'h1);
      checkOutput("held_product", product, expP);
      checkOutput("held_start_ready", {31'h0, start_ready}, 32'h0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("back_idle_valid", {31'h0, res_valid}, 32'h0);
    checkOutput("back_idle_ready", {31'h0, start_ready}, 32'h1);
  endtask

  task automatic expectQuiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1'b1;
    end
    checkOutput(name, {31'h0, seen}, 32'h0);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_start_ready"}, {31'h0, start_ready}, 32'h1);
    checkOutput({tag, "_res_valid"}, {31'h0, res_valid}, 32'h0);
    checkOutput({tag, "_busy"}, {31'h0, busy}, 32'h0);
    checkOutput({tag, "_product"}, product, 32'h0);
    checkOutput({tag, "_alu_a"}, alu_a, 32'h0);
    checkOutput({tag, "_alu_b"}, alu_b, 32'h0);
    checkOutput({tag, "_alu_op"}, {28'h0, alu_op}, 32'h2);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1;
    start_valid = 1'b0;
    res_ready = 1'b1;
    op_a = 32'h0;
    op_b = 32'h0;

    vecs.push_back('{32'd3,        32'd5,        32'd15,       0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 0});
    vecs.push_back('{32'h80000000, 32'd2,        32'h0,        0});
    vecs.push_back('{32'd6,        32'd7,        32'd42,       10});
    vecs.push_back('{32'd2,        32'd2,        32'd4,        0});
    vecs.push_back('{32'd100,      32'd0,        32'd0,        0});
    vecs.push_back('{32'd0,        32'h80000000, 32'd0,        2});
    vecs.push_back('{32'h12345678, 32'd1,        32'h12345678, 0});

    repeat (2) @(negedge clk);
    checkIdleOutputs("reset");
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expP, vecs[i].stall, 0);
    end

    // Stray start during RUN must be ignored and produce no second result.
    applyStimulus(32'd4, 32'd4, 32'd16, 0, 1);
    expectQuiet("no_extra_result", 40);

    // Reset in the middle of a 7*9 run discards it.
    start_valid = 1'b1;
    op_a = 32'd7;
    op_b = 32'd9;
    @(negedge clk);
    start_valid = 1'b0;
    checkOutput("midrun_busy", {31'h0, busy}, 32'h1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkIdleOutputs("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkIdleOutputs("after_rst");
    expectQuiet("rst_discard", 40);

    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 1000));
      applyStimulus(ra, rb, modelProduct(ra, rb), i % 3, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
